// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scan controller.
// Holds the scan state enum, column strobe patterns and the key-code width.
package keypad_pkg;

  localparam int KEY_CODE_W = 4;
  localparam int NUM_COLS   = 4;
  localparam int NUM_ROWS   = 4;

  typedef enum logic [1:0] {
    SCAN,
    CONFIRM,
    HELD
  } scan_state_e;

  // One-cold strobe per column index: a 0 marks the driven column.
  localparam logic [NUM_COLS-1:0] COL_PATTERN [NUM_COLS] = '{
    4'b1110,
    4'b1101,
    4'b1011,
    4'b0111
  };

  // Index of the lowest-numbered row pulled low; 0 when none are low.
  function automatic logic [1:0] lowest_low_row(input logic [NUM_ROWS-1:0] rows_n);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (!rows_n[i]) begin
        idx = 2'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_event_buf.sv
// Single-entry valid/ready holding register for key events with a sticky
// overflow flag raised whenever an event arrives while the entry is occupied.
module keypad_event_buf
  import keypad_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  input  logic [KEY_CODE_W-1:0] load_code,
  input  logic                  load_release,
  input  logic                  ev_ready,
  output logic                  ev_valid,
  output logic [KEY_CODE_W-1:0] ev_code,
  output logic                  ev_release,
  output logic                  overflow
);

  logic                  valid_q, valid_d;
  logic [KEY_CODE_W-1:0] code_q, code_d;
  logic                  release_q, release_d;
  logic                  overflow_q, overflow_d;
  logic                  accept;

  // A load in the same cycle as an accept refills the entry with no bubble.
  always_comb begin
    valid_d    = valid_q;
    code_d     = code_q;
    release_d  = release_q;
    overflow_d = overflow_q;
    accept     = valid_q && ev_ready;

    if (accept) begin
      valid_d = 1'b0;
    end

    if (load_valid) begin
      if (!valid_q || accept) begin
        valid_d   = 1'b1;
        code_d    = load_code;
        release_d = load_release;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      code_q     <= '0;
      release_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      code_q     <= code_d;
      release_q  <= release_d;
      overflow_q <= overflow_d;
    end
  end

  assign ev_valid   = valid_q;
  assign ev_code    = code_q;
  assign ev_release = release_q;
  assign overflow   = overflow_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad matrix scanner with debounced single-key tracking and event output.
// Define KEYPAD_RELEASE_EV_EN to also emit release events (ev_release=1).
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 4,
  parameter int DEBOUNCE_CNT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_ROWS-1:0]   row,
  output logic [NUM_COLS-1:0]   column,
  output logic                  ev_valid,
  input  logic                  ev_ready,
  output logic [KEY_CODE_W-1:0] ev_code,
  output logic                  ev_release,
  output logic                  overflow
);

  localparam int DWELL_W = $clog2(SCAN_DIV);
  localparam int CNT_W   = $clog2(DEBOUNCE_CNT + 1);

  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]   CNT_DONE   = CNT_W'(DEBOUNCE_CNT);

  logic [NUM_ROWS-1:0]   row_meta_q, row_meta_d;
  logic [NUM_ROWS-1:0]   row_sync_q, row_sync_d;
  logic [DWELL_W-1:0]    dwell_q, dwell_d;
  logic [1:0]            col_idx_q, col_idx_d;
  scan_state_e           state_q, state_d;
  logic [1:0]            cand_row_q, cand_row_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      cnt_inc;
  logic [NUM_ROWS-1:0]   lower_mask;
  logic                  sample;
  logic                  cand_low;
  logic                  lower_low;
  logic                  emit;
  logic                  emit_release;
  logic [KEY_CODE_W-1:0] emit_code;

  // Rows are asynchronous to clk, so they pass through two flops first.
  always_comb begin
    row_meta_d = row;
    row_sync_d = row_meta_q;
  end

  always_comb begin
    sample     = (dwell_q == DWELL_LAST);
    dwell_d    = sample ? '0 : dwell_q + 1'b1;
    cnt_inc    = cnt_q + 1'b1;
    lower_mask = (4'b0001 << cand_row_q) - 4'b0001;
    cand_low   = !row_sync_q[cand_row_q];
    lower_low  = |(~row_sync_q & lower_mask);
  end

  // Scan/debounce FSM; all decisions happen only on the dwell-wrap sample.
  always_comb begin
    state_d      = state_q;
    col_idx_d    = col_idx_q;
    cand_row_d   = cand_row_q;
    cnt_d        = cnt_q;
    emit         = 1'b0;
    emit_release = 1'b0;

    if (sample) begin
      case (state_q)
        SCAN: begin
          if (row_sync_q != 4'hF) begin
            cand_row_d = lowest_low_row(row_sync_q);
            if (DEBOUNCE_CNT == 1) begin
              emit    = 1'b1;
              state_d = HELD;
              cnt_d   = '0;
            end else begin
              state_d = CONFIRM;
              cnt_d   = CNT_W'(1);
            end
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end

        CONFIRM: begin
          if (cand_low && !lower_low) begin
            if (cnt_inc == CNT_DONE) begin
              emit    = 1'b1;
              state_d = HELD;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d   = SCAN;
            cnt_d     = '0;
            col_idx_d = col_idx_q + 2'd1;
          end
        end

        HELD: begin
          // Release debounce always runs so scanning resumes only after a clean release.
          if (!cand_low) begin
            if (cnt_inc == CNT_DONE) begin
`ifdef KEYPAD_RELEASE_EV_EN
              emit         = 1'b1;
              emit_release = 1'b1;
`endif
              state_d   = SCAN;
              cnt_d     = '0;
              col_idx_d = col_idx_q + 2'd1;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d = '0;
          end
        end

        default: begin
          state_d = SCAN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign emit_code = {col_idx_q, cand_row_d};

  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta_q <= 4'b1111;
      row_sync_q <= 4'b1111;
      dwell_q    <= '0;
      col_idx_q  <= 2'd0;
      state_q    <= SCAN;
      cand_row_q <= 2'd0;
      cnt_q      <= '0;
    end else begin
      row_meta_q <= row_meta_d;
      row_sync_q <= row_sync_d;
      dwell_q    <= dwell_d;
      col_idx_q  <= col_idx_d;
      state_q    <= state_d;
      cand_row_q <= cand_row_d;
      cnt_q      <= cnt_d;
    end
  end

  assign column = COL_PATTERN[col_idx_q];

  keypad_event_buf u_event_buf (
    .clk          (clk),
    .rst          (rst),
    .load_valid   (emit),
    .load_code    (emit_code),
    .load_release (emit_release),
    .ev_ready     (ev_ready),
    .ev_valid     (ev_valid),
    .ev_code      (ev_code),
    .ev_release   (ev_release),
    .overflow     (overflow)
  );

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed self-checking bench for keypad_scan_ctrl (SCAN_DIV=4, DEBOUNCE_CNT=3).
// A small matrix model turns pressed keys plus the column strobe into row levels.
module tb_keypad_scan_ctrl;

`ifdef KEYPAD_RELEASE_EV_EN
  localparam bit REL_EN = 1'b1;
`else
  localparam bit REL_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [3:0]  row;
  logic [3:0]  column;
  logic        ev_valid;
  logic        ev_ready;
  logic [3:0]  ev_code;
  logic        ev_release;
  logic        overflow;
  logic [15:0] keyMatrix;
  logic [3:0]  expCol;
  logic [3:0]  oneHot;
  logic        sawValid;
  int          checkCount;
  int          errorCount;

  keypad_scan_ctrl #(
    .SCAN_DIV     (4),
    .DEBOUNCE_CNT (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .row        (row),
    .column     (column),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_code    (ev_code),
    .ev_release (ev_release),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key bit index equals its event code {col, row}.
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (keyMatrix[c*4+r] && !column[c]) begin
          row[r] = 1'b0;
        end
      end
    end
  end

  task automatic applyStimulus(input logic [15:0] keys, input logic ready);
    keyMatrix = keys;
    ev_ready  = ready;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      errorCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitValid(input string tag);
    int n;
    n = 0;
    while (!ev_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_timeout"}, 32'(n >= 200), 0);
  endtask

  task automatic waitColumnEdge(input logic [3:0] target, input string tag);
    logic [3:0] prev;
    int n;
    bit found;
    prev  = column;
    found = 1'b0;
    n     = 0;
    while (!found && n < 200) begin
      @(negedge clk);
      n++;
      if (column == target && prev != target) found = 1'b1;
      prev = column;
    end
    checkOutput({tag, "_found"}, 32'(found), 1);
  endtask

  task automatic waitColumnLeave(input logic [3:0] cur, input string tag);
    int n;
    n = 0;
    while (column == cur && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_timeout"}, 32'(n >= 200), 0);
  endtask

  task automatic acceptEvent();
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    oneHot     = 4'b0001;
    rst        = 1'b1;
    applyStimulus(16'h0000, 1'b0);
    repeat (2) @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst_column", column, 4'b1110);
    checkOutput("rst_valid", ev_valid, 0);
    checkOutput("rst_code", ev_code, 0);
    checkOutput("rst_release", ev_release, 0);
    checkOutput("rst_overflow", overflow, 0);
    rst = 1'b0;

    $display("[TB] idle rotation");
    sawValid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      expCol = ~(oneHot << ((k / 4) % 4));
      checkOutput($sformatf("idle_col_%0d", k), column, expCol);
      if (ev_valid) sawValid = 1'b1;
    end
    checkOutput("idle_no_valid", sawValid, 0);

    $display("[TB] press col2/row1");
    applyStimulus(16'h0200, 1'b0);
    waitValid("press9");
    checkOutput("press9_code", ev_code, 4'h9);
    checkOutput("press9_release", ev_release, 0);
    checkOutput("press9_column", column, 4'b1011);
    checkOutput("press9_overflow", overflow, 0);
    acceptEvent();
    checkOutput("press9_accepted", ev_valid, 0);
    repeat (20) @(negedge clk);
    checkOutput("held9_column", column, 4'b1011);
    checkOutput("held9_no_valid", ev_valid, 0);

    applyStimulus(16'h0000, 1'b0);
    waitColumnLeave(4'b1011, "release9");
    checkOutput("release9_column", column, 4'b0111);
    checkOutput("release9_valid", ev_valid, REL_EN);
`ifdef KEYPAD_RELEASE_EV_EN
    checkOutput("release9_code", ev_code, 4'h9);
    checkOutput("release9_flag", ev_release, 1);
`endif
    acceptEvent();
    checkOutput("release9_accepted", ev_valid, 0);

    $display("[TB] bounce on col0/row1");
    waitColumnEdge(4'b1110, "bounce_align");
    applyStimulus(16'h0002, 1'b0);
    repeat (4) @(negedge clk);
    checkOutput("bounce_frozen", column, 4'b1110);
    applyStimulus(16'h0000, 1'b0);
    repeat (4) @(negedge clk);
    checkOutput("bounce_advance", column, 4'b1101);
    checkOutput("bounce_valid", ev_valid, 0);
    sawValid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ev_valid) sawValid = 1'b1;
    end
    checkOutput("bounce_no_event", sawValid, 0);

    $display("[TB] rows 1 and 3 in col0");
    applyStimulus(16'h000A, 1'b0);
    waitValid("multi");
    checkOutput("multi_code", ev_code, 4'h1);
    checkOutput("multi_release", ev_release, 0);
    checkOutput("multi_column", column, 4'b1110);
    acceptEvent();
    checkOutput("multi_accepted", ev_valid, 0);
    applyStimulus(16'h0000, 1'b0);
    waitColumnLeave(4'b1110, "multi_rel");
    checkOutput("multi_rel_column", column, 4'b1101);
    checkOutput("multi_rel_valid", ev_valid, REL_EN);
`ifdef KEYPAD_RELEASE_EV_EN
    checkOutput("multi_rel_code", ev_code, 4'h1);
    checkOutput("multi_rel_flag", ev_release, 1);
`endif
    acceptEvent();
    checkOutput("multi_rel_accepted", ev_valid, 0);

    $display("[TB] back-pressure and overflow");
    applyStimulus(16'h4000, 1'b0);
    waitValid("bp_press");
    checkOutput("bp_press_code", ev_code, 4'hE);
    checkOutput("bp_press_overflow", overflow, 0);
    applyStimulus(16'h0000, 1'b0);
    waitColumnLeave(4'b0111, "bp_release");
    checkOutput("bp_release_column", column, 4'b1110);
    checkOutput("bp_release_overflow", overflow, REL_EN);
    checkOutput("bp_release_valid", ev_valid, 1);
    checkOutput("bp_release_code", ev_code, 4'hE);
    checkOutput("bp_release_flag", ev_release, 0);
    applyStimulus(16'h0001, 1'b0);
    repeat (30) @(negedge clk);
    checkOutput("bp_drop_overflow", overflow, 1);
    checkOutput("bp_drop_code", ev_code, 4'hE);
    checkOutput("bp_drop_column", column, 4'b1110);
    applyStimulus(16'h0000, 1'b0);
    waitColumnLeave(4'b1110, "bp_drop_rel");
    checkOutput("bp_drop_rel_column", column, 4'b1101);
    acceptEvent();
    checkOutput("bp_accept_valid", ev_valid, 0);
    checkOutput("bp_sticky_overflow", overflow, 1);

    $display("[TB] reset during CONFIRM");
    waitColumnEdge(4'b1011, "rst_align");
    applyStimulus(16'h0400, 1'b0);
    repeat (6) @(negedge clk);
    checkOutput("confirm_frozen", column, 4'b1011);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_column", column, 4'b1110);
    checkOutput("midrst_valid", ev_valid, 0);
    checkOutput("midrst_overflow", overflow, 0);
    checkOutput("midrst_code", ev_code, 0);
    rst = 1'b0;
    applyStimulus(16'h0000, 1'b0);
    sawValid = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (ev_valid) sawValid = 1'b1;
    end
    checkOutput("postrst_no_event", sawValid, 0);
    checkOutput("postrst_overflow", overflow, 0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Scan controller for the 4x4 dance-pad/keypad matrix. It drives the one-cold column strobes and samples the rows at the end of each column dwell. Row samples are debounced over several consecutive readings, and each confirmed press (and optionally release) becomes one key event. Events leave through a single-entry valid/ready buffer consumed by the game logic.

## Interface
- `SCAN_DIV`, default 4: clock cycles each column is driven (dwell); minimum 2.
- `DEBOUNCE_CNT`, default 3: consecutive matching row samples required to confirm a press or a release; minimum 1.
- `clk` input 1: single clock, all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `row` input 4: matrix rows, active-low (pulled up); asynchronous to `clk`, passed through a 2-flop synchronizer inside the block.
- `column` output 4: one-cold column strobe (0 = driven).
- `ev_valid` output 1: event pending.
- `ev_ready` input 1: consumer accepts event.
- `ev_code` output 4: {col_idx[1:0], row_idx[1:0]}.
- `ev_release` output 1: 0 = press, 1 = release.
- `overflow` output 1: sticky; an event was dropped.

## Operation
- Reset values: `column`=4'b1110 (col_idx 0), `ev_valid`=0, `ev_code`=0, `ev_release`=0, `overflow`=0; state SCAN; dwell and debounce counters 0; synchronizer flops 4'b1111.
- Dwell counter counts 0..SCAN_DIV-1. The row sample is taken in the cycle where the counter equals SCAN_DIV-1, using the synchronized rows. Column changes only on dwell wrap.
- SCAN: columns rotate 1110→1101→1011→0111→1110.
  - On a sample with any row low, capture the lowest low row index plus the current col_idx as the candidate. Set the debounce count to 1 and freeze the column.
  - If DEBOUNCE_CNT=1, emit the press event immediately and go to HELD. Otherwise go to CONFIRM.
- CONFIRM: the column stays frozen.
  - A sample in which the candidate row is low and no lower-index row is low increments the count. When the count reaches DEBOUNCE_CNT, emit the press event and go to HELD.
  - Any other sample returns to SCAN; the column advances to the next column at that dwell wrap.
- HELD: the column stays frozen.
  - A sample with the candidate row high increments the release count. A sample with it low clears the count to 0.
  - When the count reaches DEBOUNCE_CNT, emit the release event if enabled and go to SCAN, advancing the column.
  - Other keys are ignored while HELD (single-key tracking).
- Event buffer:
  - On emit, if the buffer is empty, or `ev_valid && ev_ready` in the same cycle, load the new event. The new event replaces the accepted one with no bubble.
  - Otherwise drop the new event and set `overflow`.
  - `ev_valid` falls the cycle after `ev_valid && ev_ready` when nothing new is loaded.
  - `ev_code` and `ev_release` are stable while `ev_valid` is high.
- `overflow` clears only on `rst`.
- `rst` mid-operation abandons every state, including a pending event. `column` returns to 4'b1110 on the next edge.

## Timing
- Full idle scan period: 4·SCAN_DIV cycles.
- Row-to-sample latency: 2 cycles of synchronizer, plus up to one dwell.
- Press event:
  - Confirmation takes DEBOUNCE_CNT samples at SCAN_DIV spacing; the first sample is the detecting one.
  - `ev_valid` rises 1 cycle after the DEBOUNCE_CNT-th sample edge.
- Release event: `ev_valid` rises 1 cycle after the DEBOUNCE_CNT-th consecutive high sample.
- Handshake: transfer occurs on any rising edge with `ev_valid && ev_ready`. `ev_ready` may be held high permanently.

## Configuration
- Macro: `KEYPAD_RELEASE_EV_EN`.
- When defined, release events are emitted with `ev_release`=1.
- When undefined, only press events are emitted. `ev_release` is tied to 0. The HELD release debounce still runs, so scanning resumes only after a debounced release.

## Structure
- Package `keypad_pkg`: state enum (SCAN, CONFIRM, HELD), one-cold column pattern constants indexed by col_idx, and `KEY_CODE_W`=4.
- Sub-module `keypad_event_buf`: the single-entry valid/ready holding register plus sticky overflow, instantiated once.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE_CNT=3.
- No key pressed, 40 cycles → `column` steps 1110,1101,1011,0111,1110 with 4 cycles each; `ev_valid` stays 0.
- Col 2 / row 1 held low → press event with `ev_code`=4'h9, `ev_release`=0; `column` frozen at 1011. On release (macro on) → event with `ev_code`=4'h9, `ev_release`=1, then rotation resumes at 0111.
- Row 1 low for one sample only (bounce) → no event; state returns to SCAN and the column advances.
- Rows 1 and 3 low in col 0 → `ev_code`=4'h1 (lowest row wins).
- `ev_ready`=0 through press and release → press event held in the buffer, release dropped, `overflow`=1. Raising `ev_ready` for one cycle drops `ev_valid`; `overflow` stays 1 until `rst`.
- `rst` asserted during CONFIRM → next edge gives `column`=1110, `ev_valid`=0, `overflow`=0, and no event follows.
